// File: rtl/riscv_div_issue_if.sv
// Pipeline/divider/register-file bundle for the RV32 divide issue stage.
// slave is the issue block's view; master is the surrounding pipeline's view.
interface riscv_div_issue_if;
  logic        inst_valid_i;
  logic        inst_ready_o;
  logic [31:0] inst_opcode_i;
  logic [31:0] inst_pc_i;
  logic [31:0] inst_ra_operand_i;
  logic [31:0] inst_rb_operand_i;
  logic        div_opcode_valid_o;
  logic [31:0] div_opcode_opcode_o;
  logic [31:0] div_opcode_pc_o;
  logic [4:0]  div_opcode_rd_idx_o;
  logic [4:0]  div_opcode_ra_idx_o;
  logic [4:0]  div_opcode_rb_idx_o;
  logic [31:0] div_opcode_ra_operand_o;
  logic [31:0] div_opcode_rb_operand_o;
  logic        div_opcode_invalid_o;
  logic        div_writeback_valid_i;
  logic [31:0] div_writeback_value_i;
  logic        rf_wr_en_o;
  logic [4:0]  rf_wr_idx_o;
  logic [31:0] rf_wr_data_o;
  logic        busy_o;
  logic        timeout_o;

  modport slave (
    input  inst_valid_i, inst_opcode_i, inst_pc_i, inst_ra_operand_i, inst_rb_operand_i,
           div_writeback_valid_i, div_writeback_value_i,
    output inst_ready_o, div_opcode_valid_o, div_opcode_opcode_o, div_opcode_pc_o,
           div_opcode_rd_idx_o, div_opcode_ra_idx_o, div_opcode_rb_idx_o,
           div_opcode_ra_operand_o, div_opcode_rb_operand_o, div_opcode_invalid_o,
           rf_wr_en_o, rf_wr_idx_o, rf_wr_data_o, busy_o, timeout_o
  );

  modport master (
    output inst_valid_i, inst_opcode_i, inst_pc_i, inst_ra_operand_i, inst_rb_operand_i,
           div_writeback_valid_i, div_writeback_value_i,
    input  inst_ready_o, div_opcode_valid_o, div_opcode_opcode_o, div_opcode_pc_o,
           div_opcode_rd_idx_o, div_opcode_ra_idx_o, div_opcode_rb_idx_o,
           div_opcode_ra_operand_o, div_opcode_rb_operand_o, div_opcode_invalid_o,
           rf_wr_en_o, rf_wr_idx_o, rf_wr_data_o, busy_o, timeout_o
  );
endinterface

// File: rtl/riscv_div_issue.sv
// Single-slot issue stage for RV32M DIV/DIVU/REM/REMU: latch, issue, wait, write back.
// Optional WAIT watchdog enabled by defining RISCV_DIV_ISSUE_TIMEOUT_EN.
module riscv_div_issue #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  riscv_div_issue_if.slave  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, WRITE = 2'd3} state_t;

  state_t      r_state, w_next;
  logic [31:0] r_opcode, r_pc, r_ra, r_rb, r_wb_data;
  logic        w_ready, w_accept, w_is_div, w_wb_take;
  logic        w_timeout_hit, w_timeout_flag;

  // Ready is masked during reset so the pipeline sees no acceptance window.
  assign w_ready   = (r_state == IDLE) & rst_i;
  assign w_accept  = bus.inst_valid_i & w_ready;
  assign w_is_div  = (bus.inst_opcode_i[6:0] == 7'b0110011) &
                     (bus.inst_opcode_i[31:25] == 7'b0000001) & bus.inst_opcode_i[14];
  assign w_wb_take = (r_state == WAIT) & bus.div_writeback_valid_i;

`ifdef RISCV_DIV_ISSUE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_wait_cnt;
  logic          r_timeout;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      if (r_state == ISSUE)     r_wait_cnt <= '0;
      else if (r_state == WAIT) r_wait_cnt <= r_wait_cnt + CW'(1);
      if (r_state == WAIT)      r_timeout  <= w_timeout_hit;
    end
  end

  // Counter holds the number of WAIT cycles already spent; abort on the last one.
  assign w_timeout_hit  = (r_state == WAIT) & ~bus.div_writeback_valid_i &
                          (r_wait_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign w_timeout_flag = r_timeout;
`else
  assign w_timeout_hit  = 1'b0;
  assign w_timeout_flag = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept && w_is_div) w_next = ISSUE;
      ISSUE:   w_next = WAIT;
      WAIT:    if (w_wb_take || w_timeout_hit) w_next = WRITE;
      WRITE:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.inst_ready_o       = w_ready;
    bus.busy_o             = (r_state != IDLE);
    bus.div_opcode_valid_o = (r_state == ISSUE);
    bus.rf_wr_en_o         = 1'b0;
    bus.rf_wr_idx_o        = 5'd0;
    bus.rf_wr_data_o       = 32'd0;
    bus.timeout_o          = 1'b0;
    if (r_state == WRITE) begin
      bus.rf_wr_en_o   = (r_opcode[11:7] != 5'd0);
      bus.rf_wr_idx_o  = r_opcode[11:7];
      bus.rf_wr_data_o = r_wb_data;
      bus.timeout_o    = w_timeout_flag;
    end
  end

  // Non-div instructions are latched too but never leave IDLE.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_opcode  <= '0;
      r_pc      <= '0;
      r_ra      <= '0;
      r_rb      <= '0;
      r_wb_data <= '0;
    end else begin
      if (w_accept) begin
        r_opcode <= bus.inst_opcode_i;
        r_pc     <= bus.inst_pc_i;
        r_ra     <= bus.inst_ra_operand_i;
        r_rb     <= bus.inst_rb_operand_i;
      end
      if (w_wb_take)          r_wb_data <= bus.div_writeback_value_i;
      else if (w_timeout_hit) r_wb_data <= 32'hFFFF_FFFF;
    end
  end

  assign bus.div_opcode_opcode_o     = r_opcode;
  assign bus.div_opcode_pc_o         = r_pc;
  assign bus.div_opcode_rd_idx_o     = r_opcode[11:7];
  assign bus.div_opcode_ra_idx_o     = r_opcode[19:15];
  assign bus.div_opcode_rb_idx_o     = r_opcode[24:20];
  assign bus.div_opcode_ra_operand_o = r_ra;
  assign bus.div_opcode_rb_operand_o = r_rb;
  assign bus.div_opcode_invalid_o    = 1'b0;
endmodule

// File: tb/tb_riscv_div_issue.sv
// Bench for riscv_div_issue: directed scenarios plus randomized traffic against a cycle-indexed model.
module tb_riscv_div_issue;
  localparam int TO = 16;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  riscv_div_issue_if bus();
  riscv_div_issue #(.TIMEOUT_CYCLES(TO)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  int k = 0;
  bit auto_wb = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail < 40) $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, k);
    end
  endtask

  function automatic bit is_div(input logic [31:0] o);
    return (o[6:0] == 7'b0110011) && (o[31:25] == 7'b0000001) && o[14];
  endfunction

  // Model: an accepted div at edge A issues in cycle A; the first writeback seen in a
  // cycle after A makes the next cycle the write cycle, and the cycle after that is idle.
  bit          m_busy, m_wbseen, m_to;
  int          m_acc;
  logic [31:0] m_opc, m_pc, m_ra, m_rb, m_wbval;

  always @(posedge clk_i) begin
    k = k + 1;
    if (!rst_i) begin
      m_busy = 0; m_wbseen = 0; m_to = 0; m_acc = 0;
      m_opc = 0; m_pc = 0; m_ra = 0; m_rb = 0; m_wbval = 0;
    end else if (!m_busy) begin
      if (bus.inst_valid_i) begin
        m_opc = bus.inst_opcode_i; m_pc = bus.inst_pc_i;
        m_ra = bus.inst_ra_operand_i; m_rb = bus.inst_rb_operand_i;
        if (is_div(m_opc)) begin
          m_busy = 1; m_acc = k; m_wbseen = 0; m_to = 0;
        end
      end
    end else if (m_wbseen) begin
      m_busy = 0;
    end else if (k - 1 > m_acc) begin
      if (bus.div_writeback_valid_i) begin
        m_wbseen = 1; m_wbval = bus.div_writeback_value_i;
      end
`ifdef RISCV_DIV_ISSUE_TIMEOUT_EN
      else if (k - 1 - m_acc == TO) begin
        m_wbseen = 1; m_wbval = 32'hFFFF_FFFF; m_to = 1;
      end
`endif
    end
  end

  int issue_cnt = 0, issue_cyc = -1, rf_cnt = 0, rf_cyc = -1, to_cnt = 0;

  always @(negedge clk_i) begin : cmp
    bit wr;
    if (!rst_i) begin
      chk("rst_ready", bus.inst_ready_o, 0);
      chk("rst_busy", bus.busy_o, 0);
      chk("rst_issue", bus.div_opcode_valid_o, 0);
      chk("rst_rf_en", bus.rf_wr_en_o, 0);
      chk("rst_rf_data", bus.rf_wr_data_o, 0);
      chk("rst_timeout", bus.timeout_o, 0);
      chk("rst_opcode", bus.div_opcode_opcode_o, 0);
      chk("rst_ra", bus.div_opcode_ra_operand_o, 0);
    end else begin
      wr = m_busy && m_wbseen;
      chk("ready", bus.inst_ready_o, !m_busy);
      chk("busy", bus.busy_o, m_busy);
      chk("issue", bus.div_opcode_valid_o, m_busy && (k == m_acc));
      chk("opcode", bus.div_opcode_opcode_o, m_opc);
      chk("pc", bus.div_opcode_pc_o, m_pc);
      chk("rd_idx", bus.div_opcode_rd_idx_o, m_opc[11:7]);
      chk("ra_idx", bus.div_opcode_ra_idx_o, m_opc[19:15]);
      chk("rb_idx", bus.div_opcode_rb_idx_o, m_opc[24:20]);
      chk("ra_op", bus.div_opcode_ra_operand_o, m_ra);
      chk("rb_op", bus.div_opcode_rb_operand_o, m_rb);
      chk("invalid", bus.div_opcode_invalid_o, 0);
      chk("rf_en", bus.rf_wr_en_o, wr && (m_opc[11:7] != 0));
      chk("rf_idx", bus.rf_wr_idx_o, wr ? m_opc[11:7] : 5'd0);
      chk("rf_data", bus.rf_wr_data_o, wr ? m_wbval : 32'd0);
      chk("timeout", bus.timeout_o, wr && m_to);
    end
    if (bus.div_opcode_valid_o) begin issue_cnt++; issue_cyc = k; end
    if (bus.rf_wr_en_o) begin rf_cnt++; rf_cyc = k; end
    if (bus.timeout_o) to_cnt++;
  end

  task automatic tick();
    @(posedge clk_i); #1;
    if (auto_wb) begin
      bus.div_writeback_valid_i = ($urandom_range(0, 3) == 0);
      bus.div_writeback_value_i = $urandom;
    end
  endtask

  // Presents an instruction and returns just after the accepting edge; valid stays high.
  task automatic send(input logic [31:0] opc, input logic [31:0] pc,
                      input logic [31:0] ra, input logic [31:0] rb);
    bit r;
    int n;
    bus.inst_valid_i = 1; bus.inst_opcode_i = opc; bus.inst_pc_i = pc;
    bus.inst_ra_operand_i = ra; bus.inst_rb_operand_i = rb;
    n = 0;
    do begin
      r = bus.inst_ready_o;
      tick();
      n++;
    end while (!r && n < 300);
    if (!r) chk("send_accept_bound", 0, 1);
  endtask

  task automatic wb_pulse(input logic [31:0] v);
    bus.div_writeback_valid_i = 1; bus.div_writeback_value_i = v;
    tick();
    bus.div_writeback_valid_i = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_bound: got timeout expected completion");
    $fatal(1, "bench time bound");
  end

  int t0, tw, s_iss, s_rf;
  logic [31:0] opc;

  initial begin
    bus.inst_valid_i = 0; bus.inst_opcode_i = 0; bus.inst_pc_i = 0;
    bus.inst_ra_operand_i = 0; bus.inst_rb_operand_i = 0;
    bus.div_writeback_valid_i = 0; bus.div_writeback_value_i = 0;
    repeat (3) tick();
    chk("reset_ready_low", bus.inst_ready_o, 0);
    #2 rst_i = 1;
    #1;
    chk("post_reset_ready", bus.inst_ready_o, 1);
    chk("post_reset_busy", bus.busy_o, 0);
    tick();

    // DIV x1, writeback five cycles after issue
    s_iss = issue_cnt; s_rf = rf_cnt;
    send(32'h020040B3, 32'h0000_1000, 32'd9, 32'hFFFF_FFFD);
    bus.inst_valid_i = 0; t0 = k;
    chk("div_issue_live", bus.div_opcode_valid_o, 1);
    chk("div_rd_idx", bus.div_opcode_rd_idx_o, 1);
    chk("div_ra_op", bus.div_opcode_ra_operand_o, 9);
    repeat (5) tick();
    wb_pulse(32'hFFFF_FFFD);
    chk("div_rf_en", bus.rf_wr_en_o, 1);
    chk("div_rf_idx", bus.rf_wr_idx_o, 1);
    chk("div_rf_data", bus.rf_wr_data_o, 32'hFFFF_FFFD);
    tick();
    chk("div_ready_again", bus.inst_ready_o, 1);
    chk("div_issue_count", issue_cnt - s_iss, 1);
    chk("div_issue_cycle", issue_cyc - t0, 0);
    chk("div_rf_cycle", rf_cyc - t0, 6);

    // ADD is accepted and dropped
    s_iss = issue_cnt; s_rf = rf_cnt;
    send(32'h002080B3, 32'h0000_1004, 32'd1, 32'd2);
    bus.inst_valid_i = 0;
    chk("add_ready", bus.inst_ready_o, 1);
    chk("add_busy", bus.busy_o, 0);
    tick();
    chk("add_no_issue", issue_cnt - s_iss, 0);
    chk("add_no_rf", rf_cnt - s_rf, 0);

    // REM x0: full handshake, no register write
    s_iss = issue_cnt; s_rf = rf_cnt;
    send(32'h02006033, 32'h0000_1008, 32'd6, 32'd4);
    bus.inst_valid_i = 0;
    repeat (2) tick();
    wb_pulse(32'd2);
    chk("rem_write_busy", bus.busy_o, 1);
    chk("rem_rf_en", bus.rf_wr_en_o, 0);
    tick();
    chk("rem_idle", bus.inst_ready_o, 1);
    chk("rem_issue_count", issue_cnt - s_iss, 1);
    chk("rem_no_rf", rf_cnt - s_rf, 0);

    // DIVU x3 held valid across two transactions
    s_iss = issue_cnt; s_rf = rf_cnt;
    send(32'h0220D1B3, 32'h0000_100C, 32'd100, 32'd7);
    repeat (2) tick();
    wb_pulse(32'd14);
    tw = k;
    send(32'h0220D1B3, 32'h0000_100C, 32'd100, 32'd7);
    bus.inst_valid_i = 0;
    chk("divu_second_accept", k - tw, 2);
    repeat (2) tick();
    wb_pulse(32'd14);
    repeat (2) tick();
    chk("divu_issue_count", issue_cnt - s_iss, 2);
    chk("divu_rf_count", rf_cnt - s_rf, 2);

    // Reset while waiting, then a stale writeback
    s_rf = rf_cnt;
    send(32'h020040B3, 32'h0000_1010, 32'd9, 32'd3);
    bus.inst_valid_i = 0;
    repeat (2) tick();
    rst_i = 0; #1;
    chk("midrst_busy", bus.busy_o, 0);
    chk("midrst_ready", bus.inst_ready_o, 0);
    tick(); tick();
    #2 rst_i = 1;
    tick();
    wb_pulse(32'hDEAD_BEEF);
    chk("stale_wb_rf_en", bus.rf_wr_en_o, 0);
    tick();
    chk("stale_wb_ready", bus.inst_ready_o, 1);
    chk("stale_wb_no_rf", rf_cnt - s_rf, 0);

    // No writeback at all
    s_rf = rf_cnt;
    send(32'h020040B3, 32'h0000_1014, 32'd5, 32'd5);
    bus.inst_valid_i = 0; t0 = k;
`ifdef RISCV_DIV_ISSUE_TIMEOUT_EN
    repeat (TO + 1) tick();
    chk("to_rf_en", bus.rf_wr_en_o, 1);
    chk("to_rf_data", bus.rf_wr_data_o, 32'hFFFF_FFFF);
    chk("to_pulse", bus.timeout_o, 1);
    tick();
    chk("to_pulse_end", bus.timeout_o, 0);
    chk("to_ready", bus.inst_ready_o, 1);
    chk("to_count", to_cnt, 1);
`else
    repeat (100) tick();
    chk("nowb_busy", bus.busy_o, 1);
    chk("nowb_ready", bus.inst_ready_o, 0);
    chk("nowb_no_rf", rf_cnt - s_rf, 0);
    wb_pulse(32'h5);
    repeat (2) tick();
    chk("nowb_ready_after", bus.inst_ready_o, 1);
    chk("nowb_no_timeout", to_cnt, 0);
`endif

    // Randomized traffic with background writeback noise
    auto_wb = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        bus.inst_valid_i = 0;
        bus.inst_opcode_i = $urandom;
        repeat ($urandom_range(1, 3)) tick();
      end
      case ($urandom_range(0, 3))
        0, 1: opc = {7'b0000001, 5'($urandom), 5'($urandom), 1'b1, 2'($urandom),
                     ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), 7'b0110011};
        2:    opc = {7'b0000001, 5'($urandom), 5'($urandom), 1'b0, 2'($urandom),
                     5'($urandom), 7'b0110011};
        default: opc = $urandom;
      endcase
      send(opc, $urandom, $urandom, $urandom);
      if ($urandom_range(0, 1) == 0) bus.inst_valid_i = 0;
      if (i == 150) begin
        rst_i = 0;
        tick(); tick();
        #2 rst_i = 1;
        tick();
      end
    end
    bus.inst_valid_i = 0;
    repeat (20) tick();
    auto_wb = 0;
    bus.div_writeback_valid_i = 0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/riscv_div_issue.md
RISCV_DIV_ISSUE -- requirements
Module: riscv_div_issue

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 64, number of WAIT cycles before watchdog abort (used only with RISCV_DIV_ISSUE_TIMEOUT_EN).
REQ-002 Port: clk_i  in  1  single clock; all state changes on rising edge.
REQ-003 Port: rst_i  in  1  reset, asynchronous, active-low.
REQ-004 Port: inst_valid_i  in  1  pipeline presents instruction.
REQ-005 Port: inst_ready_o  out  1  block can accept instruction.
REQ-006 Port: inst_opcode_i  in  32  raw RV32 instruction word.
REQ-007 Port: inst_pc_i  in  32  instruction PC.
REQ-008 Port: inst_ra_operand_i / inst_rb_operand_i  in  32 each  rs1/rs2 values.
REQ-009 Port: div_opcode_valid_o  out  1  one-cycle issue strobe to divider.
REQ-010 Port: div_opcode_opcode_o / div_opcode_pc_o  out  32 each  latched instruction, PC.
REQ-011 Port: div_opcode_rd_idx_o / div_opcode_ra_idx_o / div_opcode_rb_idx_o  out  5 each  opcode[11:7], [19:15], [24:20].
REQ-012 Port: div_opcode_ra_operand_o / div_opcode_rb_operand_o  out  32 each  latched operands.
REQ-013 Port: div_opcode_invalid_o  out  1  constant 0.
REQ-014 Port: div_writeback_valid_i  in  1; div_writeback_value_i  in  32  divider result.
REQ-015 Port: rf_wr_en_o  out  1; rf_wr_idx_o  out  5; rf_wr_data_o  out  32  register-file write port.
REQ-016 Port: busy_o  out  1  high in every state except IDLE.
REQ-017 Port: timeout_o  out  1  watchdog-abort pulse.

Function
REQ-018 FSM states IDLE, ISSUE, WAIT, WRITE; inst_ready_o SHALL be 1 only in IDLE.
REQ-019 Accept = inst_valid_i & inst_ready_o; on accept latch opcode, PC, operands.
REQ-020 Div-class decode: opcode[6:0]=0110011, opcode[31:25]=0000001, opcode[14]=1 (DIV/DIVU/REM/REMU).
REQ-021 Accepted non-div-class instruction: discarded, FSM stays IDLE, no issue, no rf write.
REQ-022 Accepted div-class instruction: IDLE->ISSUE; div_opcode_valid_o=1 for exactly that one ISSUE cycle; ISSUE->WAIT.
REQ-023 All div_opcode_* data outputs SHALL hold latched values stable from ISSUE until return to IDLE.
REQ-024 WAIT: first cycle with div_writeback_valid_i=1 captures div_writeback_value_i, WAIT->WRITE.
REQ-025 div_writeback_valid_i outside WAIT (incl. same cycle as ISSUE) SHALL be ignored.
REQ-026 WRITE: one cycle, rf_wr_idx_o=latched rd, rf_wr_data_o=captured value, rf_wr_en_o=1 unless rd=0; WRITE->IDLE.
REQ-027 Latency: accept cycle N -> issue N+1; writeback cycle M -> rf write M+1; ready again M+2.
REQ-028 inst_valid_i while busy: no acceptance; instruction held by upstream until ready.

Reset
REQ-029 rst_i low: FSM->IDLE immediately; all outputs 0 except inst_ready_o=1 after release; latched data cleared.
REQ-030 Reset mid-operation discards in-flight result; later writeback SHALL NOT cause an rf write.

Configuration
REQ-031 Macro RISCV_DIV_ISSUE_TIMEOUT_EN defined: counter ($clog2(TIMEOUT_CYCLES+1) bits) cleared on entry to WAIT, increments per WAIT cycle; on reaching TIMEOUT_CYCLES without writeback -> WRITE with data 32'hFFFFFFFF and timeout_o=1 in that WRITE cycle.
REQ-032 Macro undefined: no counter; WAIT persists indefinitely; timeout_o tied 0.

Verification
REQ-033 DIV 0x020040B3, ra=9, rb=0xFFFFFFFD, model writeback 0xFFFFFFFD 5 cycles after issue -> one issue pulse at N+1, rf write idx 1 data 0xFFFFFFFD one cycle after writeback.
REQ-034 ADD 0x002080B3 valid -> accepted, no div_opcode_valid_o, no rf_wr_en_o, ready stays 1.
REQ-035 REM 0x02006033 (rd=0), ra=6, rb=4 -> issue occurs, writeback 2 captured, rf_wr_en_o stays 0, returns IDLE.
REQ-036 DIVU held valid back-to-back twice -> second accepted only cycle after first rf write; exactly two issue pulses.
REQ-037 rst_i low during WAIT, then writeback pulse -> outputs 0, no rf write, ready=1 after release.
REQ-038 With RISCV_DIV_ISSUE_TIMEOUT_EN, TIMEOUT_CYCLES=16, no writeback -> rf write 0xFFFFFFFF and timeout_o pulse after 16 WAIT cycles; without macro busy_o stays 1.
